// File: rtl/phys_reg_free_list.sv
// Physical register tag free list: self-filling circular FIFO of free tags shared by
// rename (one allocation per cycle) and retirement (one free per cycle), with sticky error trap.
`timescale 1ns/1ps
module phys_reg_free_list #(
  parameter int unsigned NUM_PHYS_REGS = 64,
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned TAG_WIDTH     = 6,
  parameter int unsigned POOL_DEPTH    = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int unsigned CNT_W        = $clog2(POOL_DEPTH + 1),
  localparam int unsigned PTR_W        = (POOL_DEPTH > 1) ? $clog2(POOL_DEPTH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alloc_request,
  output logic                 o_alloc_grant,
  output logic [TAG_WIDTH-1:0] o_alloc_tag,
  output logic                 o_stall,
  input  logic                 i_free_active,
  input  logic [TAG_WIDTH-1:0] i_free_tag,
  output logic [CNT_W-1:0]     o_free_count,
  output logic                 o_init_done,
  output logic                 o_error,
  output logic [1:0]           o_error_code
);

  typedef enum logic [1:0] {StInit, StRun, StError} state_e;

  localparam logic [CNT_W-1:0] CntFull = CNT_W'(POOL_DEPTH);
  localparam logic [PTR_W-1:0] PtrLast = PTR_W'(POOL_DEPTH - 1);

  state_e                 r_state, w_state_next;
  logic [PTR_W-1:0]       r_head, w_head_next;
  logic [PTR_W-1:0]       r_tail, w_tail_next;
  logic [CNT_W-1:0]       r_count, w_count_next;
  logic [NUM_PHYS_REGS-1:0] r_in_pool, w_in_pool_next;
  logic                   r_init_done, w_init_done_next;
  logic                   r_error, w_error_next;
  logic [1:0]             r_error_code, w_error_code_next;
  logic [TAG_WIDTH-1:0]   r_fifo [POOL_DEPTH];

  logic                   w_run;
  logic                   w_has_tag;
  logic                   w_free_nz;
  logic                   w_wr_en;
  logic [TAG_WIDTH-1:0]   w_wr_data;
  logic [PTR_W-1:0]       w_head_inc;
  logic [PTR_W-1:0]       w_tail_inc;

  assign w_run      = (r_state == StRun);
  assign w_has_tag  = (r_count != '0);
  assign w_free_nz  = i_free_active && (i_free_tag != '0);
  assign w_head_inc = (r_head == PtrLast) ? '0 : r_head + PTR_W'(1);
  assign w_tail_inc = (r_tail == PtrLast) ? '0 : r_tail + PTR_W'(1);

  assign o_alloc_grant = i_alloc_request && w_run && w_has_tag;
  assign o_alloc_tag   = (w_run && w_has_tag) ? r_fifo[r_head] : '0;
  assign o_stall       = i_alloc_request && !o_alloc_grant;
  assign o_free_count  = r_count;
  assign o_init_done   = r_init_done;
  assign o_error       = r_error;
  assign o_error_code  = r_error_code;

  always_comb begin
    w_state_next      = r_state;
    w_head_next       = r_head;
    w_tail_next       = r_tail;
    w_count_next      = r_count;
    w_in_pool_next    = r_in_pool;
    w_init_done_next  = r_init_done;
    w_error_next      = r_error;
    w_error_code_next = r_error_code;
    w_wr_en           = 1'b0;
    w_wr_data         = '0;
    unique case (r_state)
      StInit: begin
        if (w_free_nz) begin
          w_state_next      = StError;
          w_error_next      = 1'b1;
          w_error_code_next = 2'b11;
        end else begin
          // Tail doubles as the fill index: entry k holds tag NUM_ARCH_REGS+k.
          w_wr_en                   = 1'b1;
          w_wr_data                 = TAG_WIDTH'(NUM_ARCH_REGS) + TAG_WIDTH'(r_tail);
          w_in_pool_next[w_wr_data] = 1'b1;
          w_tail_next               = w_tail_inc;
          w_count_next              = r_count + CNT_W'(1);
          if (r_count == CntFull - CNT_W'(1)) begin
            w_state_next     = StRun;
            w_init_done_next = 1'b1;
          end
        end
      end
      StRun: begin
        if (w_free_nz && r_in_pool[i_free_tag]) begin
          w_state_next      = StError;
          w_error_next      = 1'b1;
          w_error_code_next = 2'b10;
        end else if (w_free_nz && (r_count == CntFull) && !o_alloc_grant) begin
          w_state_next      = StError;
          w_error_next      = 1'b1;
          w_error_code_next = 2'b01;
        end else begin
          if (o_alloc_grant) begin
            w_head_next                 = w_head_inc;
            w_in_pool_next[o_alloc_tag] = 1'b0;
            w_count_next                = w_count_next - CNT_W'(1);
          end
          if (w_free_nz) begin
            w_wr_en                    = 1'b1;
            w_wr_data                  = i_free_tag;
            w_in_pool_next[i_free_tag] = 1'b1;
            w_tail_next                = w_tail_inc;
            w_count_next               = w_count_next + CNT_W'(1);
          end
        end
      end
      StError: ;
      default: w_state_next = StError;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StInit;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_in_pool    <= '0;
      r_init_done  <= 1'b0;
      r_error      <= 1'b0;
      r_error_code <= 2'b00;
    end else begin
      r_state      <= w_state_next;
      r_head       <= w_head_next;
      r_tail       <= w_tail_next;
      r_count      <= w_count_next;
      r_in_pool    <= w_in_pool_next;
      r_init_done  <= w_init_done_next;
      r_error      <= w_error_next;
      r_error_code <= w_error_code_next;
    end
  end

  // Entries are only read when count != 0, so the storage itself needs no reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_fifo[r_tail] <= w_wr_data;
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed self-checking bench for phys_reg_free_list: fill, drain, wrap, error traps, async reset.
`timescale 1ns/1ps
module tb_phys_reg_free_list;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       fa = 1'b0;
  logic [5:0] ft = '0;
  logic       grant, stall, done, err;
  logic [5:0] tag, cnt;
  logic [1:0] code;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_alloc_request(req),
    .o_alloc_grant  (grant),
    .o_alloc_tag    (tag),
    .o_stall        (stall),
    .i_free_active  (fa),
    .i_free_tag     (ft),
    .o_free_count   (cnt),
    .o_init_done    (done),
    .o_error        (err),
    .o_error_code   (code)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_reset();
    rst_n = 1'b0; req = 1'b0; fa = 1'b0; ft = '0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic reset_fill();
    start_reset();
    repeat (32) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b1; fa = 1'b0;
    #1;
    n_run++; if (grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant got %0b want 0", grant); end
    n_run++; if (tag !== 6'd0) begin n_fail++; $display("FAIL reset_tag got %0d want 0", tag); end
    n_run++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %0b want 1", stall); end
    n_run++; if (cnt !== 6'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", cnt); end
    n_run++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
    n_run++; if ({err, code} !== 3'b000) begin
      n_fail++; $display("FAIL reset_error got %0b/%0b want 0/00", err, code);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      n_run++;
      if (stall !== 1'b1 || done !== 1'b0) begin
        n_fail++; $display("FAIL fill_stall k=%0d got stall=%0b done=%0b want 1/0", k, stall, done);
      end
      tick();
    end
    n_run++; if (done !== 1'b1) begin n_fail++; $display("FAIL fill_done got %0b want 1", done); end
    n_run++; if (cnt !== 6'd32) begin n_fail++; $display("FAIL fill_count got %0d want 32", cnt); end
  endtask

  // Continues from test_reset with alloc_request still high.
  task automatic test_drain();
    for (int k = 0; k < 32; k++) begin
      n_run++;
      if (grant !== 1'b1 || tag !== 6'(32 + k)) begin
        n_fail++; $display("FAIL drain_tag k=%0d got %0b/%0d want 1/%0d", k, grant, tag, 32 + k);
      end
      tick();
    end
    n_run++; if (cnt !== 6'd0) begin n_fail++; $display("FAIL drain_count got %0d want 0", cnt); end
    n_run++; if (grant !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL empty_stall got grant=%0b stall=%0b want 0/1", grant, stall);
    end
    fa = 1'b1; ft = 6'd40;
    #1;
    n_run++; if (grant !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL no_bypass got grant=%0b stall=%0b want 0/1", grant, stall);
    end
    tick();
    fa = 1'b0;
    #1;
    n_run++; if (grant !== 1'b1 || tag !== 6'd40 || cnt !== 6'd1) begin
      n_fail++; $display("FAIL refree_grant got %0b/%0d cnt=%0d want 1/40 cnt=1", grant, tag, cnt);
    end
    tick();
    req = 1'b0;
    n_run++; if (cnt !== 6'd0) begin n_fail++; $display("FAIL refree_count got %0d want 0", cnt); end
  endtask

  task automatic test_wrap();
    logic [5:0] wt [3];
    wt[0] = 6'd5; wt[1] = 6'd7; wt[2] = 6'd9;
    for (int i = 0; i < 3; i++) begin
      fa = 1'b1; ft = wt[i];
      tick();
    end
    fa = 1'b0;
    n_run++; if (cnt !== 6'd3) begin n_fail++; $display("FAIL wrap_count got %0d want 3", cnt); end
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_run++;
      if (grant !== 1'b1 || tag !== wt[i]) begin
        n_fail++; $display("FAIL wrap_tag i=%0d got %0b/%0d want 1/%0d", i, grant, tag, wt[i]);
      end
      tick();
    end
    req = 1'b0;
    n_run++; if (cnt !== 6'd0 || err !== 1'b0) begin
      n_fail++; $display("FAIL wrap_end got cnt=%0d err=%0b want 0/0", cnt, err);
    end
  endtask

  task automatic test_overflow();
    reset_fill();
    fa = 1'b1; ft = 6'd12;
    tick();
    fa = 1'b0;
    n_run++; if (err !== 1'b1 || code !== 2'b01 || cnt !== 6'd32) begin
      n_fail++; $display("FAIL overflow got err=%0b code=%0b cnt=%0d want 1/01/32", err, code, cnt);
    end
    req = 1'b1;
    #1;
    n_run++; if (grant !== 1'b0 || tag !== 6'd0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL err_nogrant got %0b/%0d/%0b want 0/0/1", grant, tag, stall);
    end
    reset_fill();
    req = 1'b1; fa = 1'b1; ft = 6'd0;
    #1;
    n_run++; if (grant !== 1'b1 || tag !== 6'd32) begin
      n_fail++; $display("FAIL full_grant got %0b/%0d want 1/32", grant, tag);
    end
    tick();
    req = 1'b0; fa = 1'b0;
    n_run++; if (cnt !== 6'd31 || err !== 1'b0) begin
      n_fail++; $display("FAIL free_p0 got cnt=%0d err=%0b want 31/0", cnt, err);
    end
    fa = 1'b1; ft = 6'd12;
    tick();
    n_run++; if (cnt !== 6'd32 || err !== 1'b0) begin
      n_fail++; $display("FAIL refill got cnt=%0d err=%0b want 32/0", cnt, err);
    end
    req = 1'b1; ft = 6'd13;
    #1;
    n_run++; if (grant !== 1'b1 || tag !== 6'd33) begin
      n_fail++; $display("FAIL full_swap_grant got %0b/%0d want 1/33", grant, tag);
    end
    tick();
    req = 1'b0; fa = 1'b0;
    n_run++; if (cnt !== 6'd32 || err !== 1'b0) begin
      n_fail++; $display("FAIL full_swap got cnt=%0d err=%0b want 32/0", cnt, err);
    end
  endtask

  task automatic test_double_free();
    reset_fill();
    fa = 1'b1; ft = 6'd50;
    tick();
    fa = 1'b0;
    n_run++; if (err !== 1'b1 || code !== 2'b10) begin
      n_fail++; $display("FAIL double_free got err=%0b code=%0b want 1/10", err, code);
    end
    req = 1'b1;
    #1;
    n_run++; if (grant !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL df_nogrant got grant=%0b stall=%0b want 0/1", grant, stall);
    end
    reset_fill();
    req = 1'b1; fa = 1'b1; ft = 6'd32;
    tick();
    req = 1'b0; fa = 1'b0;
    n_run++; if (err !== 1'b1 || code !== 2'b10) begin
      n_fail++; $display("FAIL same_tag_df got err=%0b code=%0b want 1/10", err, code);
    end
    start_reset();
    tick();
    tick();
    fa = 1'b1; ft = 6'd3;
    tick();
    fa = 1'b0;
    n_run++; if (err !== 1'b1 || code !== 2'b11 || done !== 1'b0) begin
      n_fail++; $display("FAIL init_free got err=%0b code=%0b done=%0b want 1/11/0", err, code, done);
    end
    repeat (35) tick();
    req = 1'b1;
    #1;
    n_run++; if (grant !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL init_err_stuck got grant=%0b done=%0b want 0/0", grant, done);
    end
    req = 1'b0;
  endtask

  task automatic test_async_reset();
    reset_fill();
    req = 1'b1;
    repeat (15) tick();
    req = 1'b0;
    n_run++; if (cnt !== 6'd17) begin n_fail++; $display("FAIL pre_reset_count got %0d want 17", cnt); end
    #2;
    rst_n = 1'b0;
    req = 1'b1;
    #1;
    n_run++; if (cnt !== 6'd0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL async_regs got cnt=%0d done=%0b err=%0b want 0/0/0", cnt, done, err);
    end
    n_run++; if (grant !== 1'b0 || tag !== 6'd0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL async_comb got %0b/%0d/%0b want 0/0/1", grant, tag, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (32) tick();
    n_run++; if (done !== 1'b1 || grant !== 1'b1 || tag !== 6'd32) begin
      n_fail++; $display("FAIL reinit got done=%0b grant=%0b tag=%0d want 1/1/32", done, grant, tag);
    end
    req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_drain();
    test_wrap();
    test_overflow();
    test_double_free();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
